// File: rtl/fetch_queue.sv
// Fetch stage: one outstanding word-address request to instruction memory, returned words
// queued with their PCs; FETCH_QUEUE_PERF_EN adds stall/flush performance counters.
module fetch_queue #(
  parameter int unsigned DEPTH    = 2,
  parameter logic [29:0] RESET_PC = 30'h0000_0C00
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [29:0] npc_in,
  input  logic        redirect,
  output logic [29:0] pc_out,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_out,
  output logic        imem_req,
  output logic [29:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata
`ifdef FETCH_QUEUE_PERF_EN
  ,
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_flush_cnt
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DROP
  } state_e;

  state_e        state_q, state_d;
  logic [29:0]   fetch_pc_q, fetch_pc_d;
  logic [29:0]   addr_q, addr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   last_inst_q, last_inst_d;
  logic [29:0]   pc_mem_q   [DEPTH];
  logic [29:0]   pc_mem_d   [DEPTH];
  logic [31:0]   inst_mem_q [DEPTH];
  logic [31:0]   inst_mem_d [DEPTH];

  logic          pop;
  logic          flush;
  logic          push;
  logic [CW-1:0] count_after;

  assign inst_valid = (count_q != '0);
  assign pc_out     = inst_valid ? pc_mem_q[rd_ptr_q] : fetch_pc_q;
  assign inst_out   = inst_valid ? inst_mem_q[rd_ptr_q] : last_inst_q;
  assign imem_req   = (state_q != ST_IDLE);
  assign imem_addr  = addr_q;

  always_comb begin
    pop         = inst_valid & inst_ready;
    flush       = pop & redirect;
    push        = (state_q == ST_WAIT) & imem_ack & ~flush;
    count_after = flush ? '0 : (count_q - CW'(pop));

    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    addr_d      = addr_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_after + CW'(push);
    last_inst_d = inst_valid ? inst_mem_q[rd_ptr_q] : last_inst_q;
    pc_mem_d    = pc_mem_q;
    inst_mem_d  = inst_mem_q;

    if (flush) begin
      fetch_pc_d = npc_in;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
    end else begin
      if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
      if (push) begin
        pc_mem_d[wr_ptr_q]   = addr_q;
        inst_mem_d[wr_ptr_q] = imem_rdata;
        wr_ptr_d             = wr_ptr_q + AW'(1);
        fetch_pc_d           = fetch_pc_q + 30'd1;
      end
    end

    unique case (state_q)
      ST_IDLE: begin
        // A flush in IDLE issues straight to the redirect target.
        if (count_after < DEPTH_C) begin
          state_d = ST_WAIT;
          addr_d  = fetch_pc_d;
        end
      end
      ST_WAIT: begin
        if (imem_ack)   state_d = ST_IDLE;
        else if (flush) state_d = ST_DROP;
      end
      ST_DROP: begin
        if (imem_ack) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      fetch_pc_q  <= RESET_PC;
      addr_q      <= RESET_PC;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      last_inst_q <= '0;
      pc_mem_q    <= '{default: '0};
      inst_mem_q  <= '{default: '0};
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      addr_q      <= addr_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      last_inst_q <= last_inst_d;
      pc_mem_q    <= pc_mem_d;
      inst_mem_q  <= inst_mem_d;
    end
  end

`ifdef FETCH_QUEUE_PERF_EN
  logic [31:0] stall_q, stall_d;
  logic [31:0] flushes_q, flushes_d;

  always_comb begin
    stall_d   = stall_q;
    flushes_d = flushes_q;
    if (inst_ready && !inst_valid && (stall_q != '1)) stall_d = stall_q + 32'd1;
    if (flush && (flushes_q != '1)) flushes_d = flushes_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q   <= '0;
      flushes_q <= '0;
    end else begin
      stall_q   <= stall_d;
      flushes_q <= flushes_d;
    end
  end

  assign perf_stall_cnt = stall_q;
  assign perf_flush_cnt = flushes_q;
`endif

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Fetch stage that sits directly upstream of the next-PC logic.
- Holds the fetch PC and issues word-address requests to instruction memory, one outstanding request at a time.
- Buffers returned instructions with their PCs in a small FIFO and presents the head to decode/execute with a valid/ready handshake.
- Drives the head PC to the next-PC logic and reloads the fetch PC from the next-PC result on redirect (jump or taken branch).

Parameters:
- DEPTH, 2, FIFO entries; power of 2, at least 2.
- RESET_PC, 30'h0000_0C00, word address loaded at reset (byte address 0x0000_3000).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- npc_in  in  30  next-PC result computed from pc_out.
- redirect  in  1  the consumed instruction changes control flow; sampled only when the head is consumed.
- pc_out  out  30  to the next-PC logic: head entry PC when inst_valid=1, else fetch_pc.
- inst_valid  out  1  head FIFO entry is valid.
- inst_ready  in  1  consumer accepts the head entry.
- inst_out  out  32  head instruction word.
- imem_req  out  1  memory request; held high until imem_ack.
- imem_addr  out  30  word address of the request; stable while imem_req=1.
- imem_ack  in  1  data valid this cycle; completes the request.
- imem_rdata  in  32  instruction word returned with imem_ack.

Behaviour:
- Reset (async, rst_n=0):
  - fetch_pc=RESET_PC; FIFO empty; state=IDLE.
  - imem_req=0, inst_valid=0, inst_out=0, pc_out=RESET_PC; imem_addr=RESET_PC.
  - Takes effect immediately, mid-request included. An ack arriving after release is ignored because the state is IDLE.
- Handshakes:
  - pop = inst_valid & inst_ready.
  - push = imem_ack in state WAIT.
- State machine:
  - IDLE: no request. Go to WAIT (imem_req=1, imem_addr=fetch_pc) when count + pending < DEPTH, where count is the occupancy after this cycle's pop.
  - WAIT: request outstanding.
    - On ack with no flush: push {fetch_pc, imem_rdata}, fetch_pc<=fetch_pc+1, go to IDLE.
    - IDLE re-issues on the next cycle, so throughput is at most one fetch per 2 cycles plus memory latency.
  - DROP: request outstanding, result to be discarded. On ack: discard data, go to IDLE; no fetch_pc change.
- Flush = pop & redirect. In the same edge:
  - FIFO cleared; a same-cycle push is suppressed.
  - fetch_pc<=npc_in.
  - If state is WAIT without ack this cycle, go to DROP.
  - If state is WAIT with ack this cycle, the data is dropped and the state goes to IDLE.
  - If state is DROP, stay in DROP unless ack.
- Pop without redirect advances the head. The next-PC logic's sequential result equals the next entry's PC, so it is not checked.
- Simultaneous push and pop (no flush): count unchanged; FIFO ordering preserved.
- Full: no request is issued. A request never begins unless a slot is guaranteed, so an ack never arrives when the FIFO is full.
- Empty: inst_valid=0, pc_out=fetch_pc, inst_out holds its last value.
- fetch_pc+1 wraps modulo 2^30 (3FFF_FFFF -> 0).
- imem_req and imem_addr come from registers only; there is no combinational path from imem_ack.
- Pointers are log2(DEPTH) bits and wrap naturally. Count is log2(DEPTH)+1 bits.

Optional Feature:
- Macro: FETCH_QUEUE_PERF_EN.
- Defined:
  - Adds outputs perf_stall_cnt[31:0] (cycles with inst_ready=1 & inst_valid=0) and perf_flush_cnt[31:0] (flush events).
  - Both are reset to 0 by rst_n and saturate at 32'hFFFF_FFFF.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset release, memory acks 1 cycle after req, inst_ready=1 -> imem_addr sequence 0C00, 0C01, 0C02; inst_out/pc_out pairs match; first inst_valid no later than cycle 3 after reset.
- inst_ready=0, DEPTH=2 -> exactly 2 requests issued, then imem_req stays 0 and inst_valid=1 holds entry 0C00; raise inst_ready -> fetch resumes at 0C02.
- Pop 0C00 with redirect=1, npc_in=0D10 while the request for 0C01 is pending -> FIFO cleared, state DROP; the returned 0C01 data is discarded; next imem_addr=0D10; next inst_out is the 0D10 word.
- Redirect in the same cycle as imem_ack -> acked data not pushed, inst_valid=0 next cycle, next request at npc_in.
- fetch_pc=3FFF_FFFF acked -> next imem_addr=0000_0000.
- rst_n low while imem_req=1 -> imem_req=0 immediately (same cycle); a late ack after release does not push; fetch restarts at 0C00.
